// File: rtl/rv_iommu_hpm_evt_sched_pkg.sv
// Shared types for the HPM event scheduler: event indices and the queued entry layout.
package rv_iommu_hpm_evt_sched_pkg;

  localparam int unsigned HPM_N_EVT = 6;

  typedef enum logic [2:0] {
    UT_REQ     = 3'd0,
    IOTLB_MISS = 3'd1,
    DDTW       = 3'd2,
    PDTW       = 3'd3,
    S1_PTW     = 3'd4,
    S2_PTW     = 3'd5
  } hpm_evt_idx_e;

  typedef struct packed {
    logic [HPM_N_EVT-1:0] mask;
    logic [23:0]          did;
    logic [19:0]          pid;
    logic [19:0]          pscid;
    logic [15:0]          gscid;
    logic                 pid_v;
  } hpm_evt_entry_t;

endpackage

// File: rtl/rv_iommu_hpm_evt_sched_if.sv
// Valid/ready stream carrying one scheduled event entry to the HPM match/increment logic.
interface rv_iommu_hpm_evt_sched_if;
  import rv_iommu_hpm_evt_sched_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [HPM_N_EVT-1:0] mask;
  logic [23:0]          did;
  logic [19:0]          pid;
  logic [19:0]          pscid;
  logic [15:0]          gscid;
  logic                 pid_v;

  modport master (output valid, mask, did, pid, pscid, gscid, pid_v, input ready);
  modport slave  (input valid, mask, did, pid, pscid, gscid, pid_v, output ready);

endinterface

// File: rtl/rv_iommu_hpm_evt_fifo.sv
// In-order queue of event entries with synchronous reset, flush and an occupancy output.
module rv_iommu_hpm_evt_fifo
  import rv_iommu_hpm_evt_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  hpm_evt_entry_t wdata_i,
  output hpm_evt_entry_t rdata_o,
  output logic [LvlW-1:0] level_o,
  output logic           full_o,
  output logic           empty_o
);

  hpm_evt_entry_t  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] cnt_q;

  // Caller guarantees no push when full without a pop, and no pop when empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = cnt_q;
  assign full_o  = (cnt_q == LvlW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rv_iommu_hpm_evt_sched.sv
// Edge-detects translation events, snapshots their IDs into queued entries and accounts for drops.
module rv_iommu_hpm_evt_sched
  import rv_iommu_hpm_evt_sched_pkg::*;
#(
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned DROP_CNT_W = 16,
  localparam int unsigned LvlW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  tr_request_i,
  input  logic                  iotlb_miss_i,
  input  logic                  ddt_walk_i,
  input  logic                  pdt_walk_i,
  input  logic                  s1_ptw_i,
  input  logic                  s2_ptw_i,
  input  logic [23:0]           did_i,
  input  logic [19:0]           pid_i,
  input  logic [19:0]           pscid_i,
  input  logic [15:0]           gscid_i,
  input  logic                  pid_v_i,
  rv_iommu_hpm_evt_sched_if.master evt,
  output logic [LvlW-1:0]       level_o,
  output logic                  drop_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                  clr_drop_i
);

  logic [HPM_N_EVT-1:0]  ev_vec, prev_q, rise;
  logic                  push, pop, fifo_push, drop_d, drop_q;
  logic                  full, empty;
  logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;
  hpm_evt_entry_t        wdata, head;

  always_comb begin
    ev_vec                   = '0;
    ev_vec[int'(UT_REQ)]     = tr_request_i;
    ev_vec[int'(IOTLB_MISS)] = iotlb_miss_i;
    ev_vec[int'(DDTW)]       = ddt_walk_i;
    ev_vec[int'(PDTW)]       = pdt_walk_i;
    ev_vec[int'(S1_PTW)]     = s1_ptw_i;
    ev_vec[int'(S2_PTW)]     = s2_ptw_i;
  end

  assign rise      = ev_vec & ~prev_q;
  assign push      = enable_i & (|rise);
  assign pop       = evt.valid & evt.ready;
  assign fifo_push = push & (~full | pop);
  assign drop_d    = push & full & ~pop;

  assign wdata = '{mask: rise, did: did_i, pid: pid_i, pscid: pscid_i, gscid: gscid_i,
                   pid_v: pid_v_i};

  rv_iommu_hpm_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~enable_i),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Clear wins over increment, but a drop in the clearing cycle still counts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_drop_i) begin
      drop_cnt_d = DROP_CNT_W'(drop_d);
    end else if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= ev_vec;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head fields read as zero while the queue is empty so idle outputs are clean.
  assign evt.valid  = ~empty;
  assign evt.mask   = empty ? '0 : head.mask;
  assign evt.did    = empty ? '0 : head.did;
  assign evt.pid    = empty ? '0 : head.pid;
  assign evt.pscid  = empty ? '0 : head.pscid;
  assign evt.gscid  = empty ? '0 : head.gscid;
  assign evt.pid_v  = empty ? 1'b0 : head.pid_v;
  assign drop_o     = drop_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rv_iommu_hpm_evt_sched.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_rv_iommu_hpm_evt_sched;
  import rv_iommu_hpm_evt_sched_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DROP_CNT_W = 2;
  localparam int unsigned CNT_MAX    = (1 << DROP_CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [5:0]  ev;
  logic [23:0] did;
  logic [19:0] pid, pscid;
  logic [15:0] gscid;
  logic        pid_v;
  logic [2:0]  level;
  logic        drop;
  logic [DROP_CNT_W-1:0] drop_cnt;

  rv_iommu_hpm_evt_sched_if evt_if ();

  rv_iommu_hpm_evt_sched #(
    .DEPTH      (DEPTH),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (en),
    .tr_request_i (ev[0]),
    .iotlb_miss_i (ev[1]),
    .ddt_walk_i   (ev[2]),
    .pdt_walk_i   (ev[3]),
    .s1_ptw_i     (ev[4]),
    .s2_ptw_i     (ev[5]),
    .did_i        (did),
    .pid_i        (pid),
    .pscid_i      (pscid),
    .gscid_i      (gscid),
    .pid_v_i      (pid_v),
    .evt          (evt_if),
    .level_o      (level),
    .drop_o       (drop),
    .drop_cnt_o   (drop_cnt),
    .clr_drop_i   (clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus previous-event vector and drop counter.
  hpm_evt_entry_t mq[$];
  logic [5:0]     m_prev = '0;
  int             m_cnt  = 0;
  bit             m_drop = 0;

  task automatic model_step();
    hpm_evt_entry_t e;
    logic [5:0] r;
    bit do_pop, nd;
    nd = 0;
    if (rst) begin
      mq.delete();
      m_prev = '0;
      m_cnt  = 0;
      m_drop = 0;
      return;
    end
    r      = ev & ~m_prev;
    m_prev = ev;
    do_pop = (mq.size() > 0) && evt_if.ready;
    if (!en) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (r != 0) begin
        if (mq.size() < DEPTH) begin
          e = '{mask: r, did: did, pid: pid, pscid: pscid, gscid: gscid, pid_v: pid_v};
          mq.push_back(e);
        end else begin
          nd = 1;
        end
      end
    end
    if (clr) m_cnt = nd ? 1 : 0;
    else if (nd && m_cnt < CNT_MAX) m_cnt++;
    m_drop = nd;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        rst, en;
    bit [5:0]  ev;
    bit        rdy, clr;
    bit [23:0] did;
    bit        pid_v;
    bit [19:0] pid;
    bit        e_valid;
    bit [5:0]  e_mask;
    int        e_level;
    bit        e_drop;
    int        e_cnt;
    bit [23:0] e_did;
    bit [19:0] e_pid;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit [5:0] v, bit rd, bit c, bit [23:0] d, bit pv,
                              bit [19:0] p, bit ev_, bit [5:0] em, int el, bit ed, int ec,
                              bit [23:0] edid, bit [19:0] epid);
    vec_t t;
    t = '{rst: r, en: e, ev: v, rdy: rd, clr: c, did: d, pid_v: pv, pid: p, e_valid: ev_,
          e_mask: em, e_level: el, e_drop: ed, e_cnt: ec, e_did: edid, e_pid: epid};
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    rst = 1; en = 0; clr = 0; ev = '0; did = '0; pid = '0; pscid = '0; gscid = '0; pid_v = 0;
    evt_if.ready = 0;

    //              rst en ev    rdy clr did      pv pid      | val mask lvl drp cnt did   pid
    tbl.push_back(mk(1, 0, 6'h00, 0, 0, 24'h0,     0, 20'h0,     0, 6'h00, 0, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h02, 1, 0, 24'h123456, 0, 20'h0,    1, 6'h02, 1, 0, 0, 24'h123456, 0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0,     0, 20'h0,     0, 6'h00, 0, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h0C, 0, 0, 24'h0,     1, 20'hABCDE, 1, 6'h0C, 1, 0, 0, 24'h0, 20'hABCDE));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0,     0, 20'h0,     0, 6'h00, 0, 0, 0, 24'h0, 20'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h0, 0, 20'h0, 1, 6'h20, 1, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 0, 24'h0, 0, 20'h0, 1, 6'h20, 1, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h0, 0, 20'h0, 1, 6'h20, 2, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 1, 6'h20, 1, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 0, 6'h00, 0, 0, 0, 24'h0, 20'h0));
    // Five distinct edges into a depth-4 queue, then drain in order.
    tbl.push_back(mk(0, 1, 6'h01, 0, 0, 24'h1, 0, 20'h0, 1, 6'h01, 1, 0, 0, 24'h1, 20'h0));
    tbl.push_back(mk(0, 1, 6'h02, 0, 0, 24'h2, 0, 20'h0, 1, 6'h01, 2, 0, 0, 24'h1, 20'h0));
    tbl.push_back(mk(0, 1, 6'h04, 0, 0, 24'h3, 0, 20'h0, 1, 6'h01, 3, 0, 0, 24'h1, 20'h0));
    tbl.push_back(mk(0, 1, 6'h08, 0, 0, 24'h4, 0, 20'h0, 1, 6'h01, 4, 0, 0, 24'h1, 20'h0));
    tbl.push_back(mk(0, 1, 6'h10, 0, 0, 24'h5, 0, 20'h0, 1, 6'h01, 4, 1, 1, 24'h1, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 1, 6'h02, 3, 0, 1, 24'h2, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 1, 6'h04, 2, 0, 1, 24'h3, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 1, 6'h08, 1, 0, 1, 24'h4, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0, 0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    // Refill, then full + push + pop, then saturating drops and clear priority.
    tbl.push_back(mk(0, 1, 6'h01, 0, 0, 24'h11, 0, 20'h0, 1, 6'h01, 1, 0, 1, 24'h11, 20'h0));
    tbl.push_back(mk(0, 1, 6'h02, 0, 0, 24'h22, 0, 20'h0, 1, 6'h01, 2, 0, 1, 24'h11, 20'h0));
    tbl.push_back(mk(0, 1, 6'h04, 0, 0, 24'h33, 0, 20'h0, 1, 6'h01, 3, 0, 1, 24'h11, 20'h0));
    tbl.push_back(mk(0, 1, 6'h08, 0, 0, 24'h44, 0, 20'h0, 1, 6'h01, 4, 0, 1, 24'h11, 20'h0));
    tbl.push_back(mk(0, 1, 6'h10, 1, 0, 24'h55, 0, 20'h0, 1, 6'h02, 4, 0, 1, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h66, 0, 20'h0, 1, 6'h02, 4, 1, 2, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 0, 2, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 1, 3, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 0, 3, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 1, 3, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 0, 3, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 0, 24'h0,  0, 20'h0, 1, 6'h02, 4, 1, 3, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 1, 24'h0,  0, 20'h0, 1, 6'h02, 4, 0, 0, 24'h22, 20'h0));
    tbl.push_back(mk(0, 1, 6'h20, 0, 1, 24'h0,  0, 20'h0, 1, 6'h02, 4, 1, 1, 24'h22, 20'h0));
    // Three queued, then disable flushes; edges while disabled and held events are ignored.
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0,  0, 20'h0, 1, 6'h04, 3, 0, 1, 24'h33, 20'h0));
    tbl.push_back(mk(0, 0, 6'h00, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    tbl.push_back(mk(0, 0, 6'h01, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    tbl.push_back(mk(0, 0, 6'h03, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h03, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 1, 24'h0, 20'h0));
    // Mid-run reset; an event high in the first cycle after reset counts as an edge.
    tbl.push_back(mk(0, 1, 6'h04, 0, 0, 24'h77, 0, 20'h0, 1, 6'h04, 1, 0, 1, 24'h77, 20'h0));
    tbl.push_back(mk(1, 1, 6'h04, 0, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 0, 24'h0, 20'h0));
    tbl.push_back(mk(0, 1, 6'h04, 0, 0, 24'h88, 0, 20'h0, 1, 6'h04, 1, 0, 0, 24'h88, 20'h0));
    tbl.push_back(mk(0, 1, 6'h00, 1, 0, 24'h0,  0, 20'h0, 0, 6'h00, 0, 0, 0, 24'h0, 20'h0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; ev = tbl[i].ev; evt_if.ready = tbl[i].rdy;
      clr = tbl[i].clr; did = tbl[i].did; pid_v = tbl[i].pid_v; pid = tbl[i].pid;
      pscid = '0; gscid = '0;
      cycle();
      chk($sformatf("v%0d.valid", i), evt_if.valid, tbl[i].e_valid);
      chk($sformatf("v%0d.mask", i),  evt_if.mask,  tbl[i].e_mask);
      chk($sformatf("v%0d.level", i), level,        tbl[i].e_level);
      chk($sformatf("v%0d.drop", i),  drop,         tbl[i].e_drop);
      chk($sformatf("v%0d.cnt", i),   drop_cnt,     tbl[i].e_cnt);
      chk($sformatf("v%0d.did", i),   evt_if.did,   tbl[i].e_did);
      chk($sformatf("v%0d.pid", i),   evt_if.pid,   tbl[i].e_pid);
    end

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      hpm_evt_entry_t h;
      rst          = ($urandom_range(0, 299) == 0);
      en           = ($urandom_range(0, 15) != 0);
      clr          = ($urandom_range(0, 19) == 0);
      ev           = 6'($urandom) & 6'($urandom);
      evt_if.ready = ($urandom_range(0, 2) == 0);
      did          = 24'($urandom);
      pid          = 20'($urandom);
      pscid        = 20'($urandom);
      gscid        = 16'($urandom);
      pid_v        = 1'($urandom);
      cycle();
      h = (mq.size() > 0) ? mq[0] : '0;
      chk("rnd.valid", evt_if.valid, mq.size() > 0);
      chk("rnd.level", level,        mq.size());
      chk("rnd.drop",  drop,         m_drop);
      chk("rnd.cnt",   drop_cnt,     m_cnt);
      chk("rnd.mask",  evt_if.mask,  h.mask);
      chk("rnd.did",   evt_if.did,   h.did);
      chk("rnd.pid",   evt_if.pid,   h.pid);
      chk("rnd.pscid", evt_if.pscid, h.pscid);
      chk("rnd.gscid", evt_if.gscid, h.gscid);
      chk("rnd.pid_v", evt_if.pid_v, h.pid_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
